// File: rtl/issue_alu_fifo.sv
// Purpose: FWFT queue carrying issue_execute_pack_t from the issue stage to execute_alu.
// Latency: head is read combinationally; a pushed packet is visible one edge after its push.
// Backpressure: full is raised when no entry is free; a push while full is dropped, a pop while empty is ignored.

package issue_alu_fifo_pkg;

   // Packet handed from issue to the ALU execute stage.
   typedef struct packed {
      logic [5:0]  rob_id;
      logic [4:0]  alu_op;
      logic [4:0]  rd_addr;
      logic        rd_we;
      logic [31:0] src1_val;
      logic [31:0] src2_val;
      logic [31:0] imm;
   } issue_execute_pack_t;

endpackage

module issue_alu_fifo
   import issue_alu_fifo_pkg::*;
#(
   parameter int DEPTH = 4,                        // power of two, at least 2
   localparam int PTR_W = $clog2(DEPTH),
   localparam int DATA_W = $bits(issue_execute_pack_t),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] issue_alu_fifo_data_in,
   input  logic              issue_alu_fifo_push,
   output logic              issue_alu_fifo_full,
   input  logic              issue_alu_fifo_flush,
   output logic [DATA_W-1:0] issue_alu_fifo_data_out,
   output logic              issue_alu_fifo_data_out_valid,
   input  logic              issue_alu_fifo_pop,
   output logic [CNT_W-1:0]  issue_alu_fifo_count,
   output logic              issue_alu_fifo_empty
);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [PTR_W:0]    rptr_q, rptr_d;
   logic [PTR_W:0]    wptr_q, wptr_d;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [PTR_W:0]    ptr_diff;
   logic              full;
   logic              empty;
   logic              push_acc;
   logic              pop_acc;
   logic              wr_en;

   // Occupancy flags derived purely from the pointer pair.
   always_comb begin
      ptr_diff = wptr_q - rptr_q;
      empty    = (rptr_q == wptr_q);
      full     = (rptr_q[PTR_W-1:0] == wptr_q[PTR_W-1:0]) &&
                 (rptr_q[PTR_W] != wptr_q[PTR_W]);
   end

   // Acceptance and next-pointer logic; flush overrides both push and pop.
   // full is taken from the current state, so a push alongside a pop on a full queue is dropped.
   always_comb begin
      push_acc = issue_alu_fifo_push && !full;
      pop_acc  = issue_alu_fifo_pop && !empty;
      wr_en    = push_acc && !issue_alu_fifo_flush;
      wptr_d   = wptr_q + {{PTR_W{1'b0}}, push_acc};
      rptr_d   = rptr_q + {{PTR_W{1'b0}}, pop_acc};
      if (issue_alu_fifo_flush) begin
         wptr_d = '0;
         rptr_d = '0;
      end
   end

   // Pointer registers, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rptr_q <= '0;
         wptr_q <= '0;
      end else begin
         rptr_q <= rptr_d;
         wptr_q <= wptr_d;
      end
   end

   // Storage array is deliberately left unreset; validity comes from the pointers.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wptr_q[PTR_W-1:0]] <= issue_alu_fifo_data_in;
      end
   end

   // Outputs are combinational from state; data_out is forced to zero when nothing is held.
   always_comb begin
      issue_alu_fifo_full           = full;
      issue_alu_fifo_empty          = empty;
      issue_alu_fifo_data_out_valid = !empty;
      issue_alu_fifo_count          = CNT_W'(ptr_diff);
      issue_alu_fifo_data_out       = empty ? '0 : mem_q[rptr_q[PTR_W-1:0]];
   end

   // Structural invariants of the pointer pair.
   a_count_bound : assert property (@(posedge clk) disable iff (rst)
      ptr_diff <= (PTR_W + 1)'(DEPTH));
   a_full_empty_excl : assert property (@(posedge clk) disable iff (rst)
      !(full && empty));

   // Producer/consumer protocol slips: harmless here, but worth seeing in coverage.
   c_push_while_full : cover property (@(posedge clk) disable iff (rst)
      issue_alu_fifo_push && full);
   c_pop_while_empty : cover property (@(posedge clk) disable iff (rst)
      issue_alu_fifo_pop && empty);

endmodule

// File: tb/tb_issue_alu_fifo.sv
// Bench for issue_alu_fifo (DEPTH=4): directed plan followed by randomized traffic.
// Expected packets are queued when issued; a negedge monitor checks each consumed head.

module tb_issue_alu_fifo;
   import issue_alu_fifo_pkg::*;

   localparam int DEPTH = 4;
   localparam int DW    = $bits(issue_execute_pack_t);

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] din;
   logic          push, pop, flush;
   logic          full, empty, valid;
   logic [DW-1:0] dout;
   logic [2:0]    count;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference contents of the queue, oldest first.
   issue_execute_pack_t exp_q[$];

   always #5 clk = ~clk;

   issue_alu_fifo #(.DEPTH(DEPTH)) dut (
      .clk                           (clk),
      .rst                           (rst),
      .issue_alu_fifo_data_in        (din),
      .issue_alu_fifo_push           (push),
      .issue_alu_fifo_full           (full),
      .issue_alu_fifo_flush          (flush),
      .issue_alu_fifo_data_out       (dout),
      .issue_alu_fifo_data_out_valid (valid),
      .issue_alu_fifo_pop            (pop),
      .issue_alu_fifo_count          (count),
      .issue_alu_fifo_empty          (empty)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic issue_execute_pack_t mk_pkt(input int rob);
      issue_execute_pack_t p;
      p.rob_id   = 6'(rob);
      p.alu_op   = 5'($urandom());
      p.rd_addr  = 5'($urandom());
      p.rd_we    = 1'($urandom());
      p.src1_val = $urandom();
      p.src2_val = $urandom();
      p.imm      = $urandom();
      return p;
   endfunction

   // Compare status outputs and head against the reference queue.
   task automatic check_occ();
      int sz;
      sz = exp_q.size();
      check("count", 128'(count), 128'(sz));
      check("empty", 128'(empty), 128'(sz == 0));
      check("full",  128'(full),  128'(sz == DEPTH));
      check("valid", 128'(valid), 128'(sz != 0));
      if (sz == 0) check("data_zero", 128'(dout), 128'(0));
      else         check("head", 128'(dout), 128'(exp_q[0]));
   endtask

   // One cycle: check current state, drive inputs, update the reference, advance past the edge.
   task automatic cycle(input bit p, input int rob, input bit po, input bit f);
      issue_execute_pack_t pkt;
      check_occ();
      pkt   = mk_pkt(rob);
      din   = pkt;
      push  = p;
      pop   = po;
      flush = f;
      if (f) begin
         exp_q.delete();
      end else if (p && exp_q.size() < DEPTH) begin
         exp_q.push_back(pkt);
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: every consumed head must be the oldest expected packet.
   always @(negedge clk) begin
      issue_execute_pack_t e;
      if (!rst && pop && valid && !flush) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL pop_unexpected: got %0h expected no valid head at %0t", dout, $time);
         end else begin
            e = exp_q.pop_front();
            check("pop_data", 128'(dout), 128'(e));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst   = 1'b1;
      din   = '0;
      push  = 1'b0;
      pop   = 1'b0;
      flush = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_occ();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Idle after reset.
      repeat (10) cycle(0, 0, 0, 0);

      // Fill to full, then a push that must be dropped.
      for (int i = 1; i <= 4; i++) cycle(1, i, 0, 0);
      cycle(1, 5, 0, 0);
      // Push+pop while full: 1 leaves, 5 is dropped.
      cycle(1, 5, 1, 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);
      cycle(0, 0, 0, 0);

      // Streaming with a 2-entry prefill across several wraps.
      cycle(1, 20, 0, 0);
      cycle(1, 21, 0, 0);
      for (int i = 0; i < 20; i++) cycle(1, 22 + i, 1, 0);
      cycle(0, 0, 1, 0);
      cycle(0, 0, 1, 0);
      cycle(0, 0, 0, 0);

      // Flush with simultaneous push and pop, then a fresh push.
      cycle(1, 30, 0, 0);
      cycle(1, 31, 0, 0);
      cycle(1, 32, 0, 0);
      cycle(1, 9, 1, 1);
      cycle(1, 10, 0, 0);
      cycle(0, 0, 1, 0);
      cycle(0, 0, 0, 0);

      // Asynchronous reset mid-cycle with two entries held.
      cycle(1, 40, 0, 0);
      cycle(1, 41, 0, 0);
      push = 1'b0;
      pop  = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("async_empty", 128'(empty), 128'(1));
      check("async_valid", 128'(valid), 128'(0));
      check("async_count", 128'(count), 128'(0));
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      cycle(1, 42, 0, 0);
      cycle(0, 0, 1, 0);
      cycle(0, 0, 0, 0);

      // Randomized traffic including occasional flushes and protocol slips.
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 9) < 6, int'($urandom_range(0, 63)),
               $urandom_range(0, 9) < 5, $urandom_range(0, 29) == 0);
      end
      while (exp_q.size() != 0) cycle(0, 0, 1, 0);
      cycle(0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
